// File: rtl/cl_ocl_csr_pkg.sv
// Shared definitions for the OCL AXI-Lite CSR bank: register offsets, response codes, FSM states.
package cl_ocl_csr_pkg;

    localparam logic [11:0] OFF_ID      = 12'h000;
    localparam logic [11:0] OFF_CTRL    = 12'h004;
    localparam logic [11:0] OFF_CNT_LO  = 12'h008;
    localparam logic [11:0] OFF_CNT_HI  = 12'h00C;
    localparam logic [11:0] OFF_VLED    = 12'h010;
    localparam logic [11:0] OFF_SCRATCH = 12'h020;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WIDLE, WRESP} wr_state_e;
    typedef enum logic {RIDLE, RRESP} rd_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = new_val[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/cl_ocl_csr_cycle_cnt.sv
// Free-running 64-bit cycle counter; a read of the low word snapshots the high word.
module cl_ocl_csr_cycle_cnt (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi_snap
);

    logic [63:0] cnt_q;
    logic [31:0] snap_q;

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            cnt_q  <= '0;
            snap_q <= '0;
        end else begin
            if (clr) begin
                cnt_q <= '0;
            end else if (en) begin
                cnt_q <= cnt_q + 64'd1;
            end
            // Pre-edge value pairs with the low word returned on the same AR edge.
            if (snap) snap_q <= cnt_q[63:32];
        end
    end

    assign cnt_lo      = cnt_q[31:0];
    assign cnt_hi_snap = snap_q;

endmodule

// File: rtl/cl_ocl_csr.sv
// AXI-Lite CSR bank on the OCL (AppPF BAR0) path: ID, control, cycle counter, VLED, scratch.
module cl_ocl_csr
    import cl_ocl_csr_pkg::*;
#(
    parameter int unsigned NUM_SCRATCH  = 4,
    parameter logic [31:0] ID_VALUE     = 32'hC0DE_0001,
    parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_DEAD
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] awaddr,
    input  logic        wvalid,
    output logic        wready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic        bvalid,
    input  logic        bready,
    output logic [1:0]  bresp,
    input  logic        arvalid,
    output logic        arready,
    input  logic [31:0] araddr,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic [15:0] vled
);

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic        aw_held_q, w_held_q;
    logic [11:0] awaddr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q;
    logic        ctrl_en_q, cnt_clr_q;
    logic [15:0] vled_q, vled_new;
    logic [31:0] scratch_q [NUM_SCRATCH];

    logic                   aw_hs, w_hs, ar_hs, commit;
    logic [11:0]            wr_off, rd_off;
    logic [31:0]            wr_data, rd_data;
    logic [3:0]             wr_strb;
    logic                   wr_ctrl, wr_vled, wr_ok, rd_ok;
    logic [NUM_SCRATCH-1:0] wr_scr;
    logic [31:0]            cnt_lo, cnt_hi_snap;
    logic                   unused_addr;

    assign unused_addr = ^{awaddr[31:12], awaddr[1:0], araddr[31:12], araddr[1:0]};

    // Readies are gated by reset so they read 0 while reset is asserted.
    assign awready = rst_main_n & (wr_state_q == WIDLE) & ~aw_held_q;
    assign wready  = rst_main_n & (wr_state_q == WIDLE) & ~w_held_q;
    assign arready = rst_main_n & (rd_state_q == RIDLE);
    assign bvalid  = (wr_state_q == WRESP);
    assign rvalid  = (rd_state_q == RRESP);
    assign bresp   = bresp_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign vled    = vled_q;

    assign aw_hs = awvalid & awready;
    assign w_hs  = wvalid & wready;
    assign ar_hs = arvalid & arready;

    always_comb begin
        wr_off  = aw_held_q ? awaddr_q : {awaddr[11:2], 2'b00};
        wr_data = w_held_q ? wdata_q : wdata;
        wr_strb = w_held_q ? wstrb_q : wstrb;
        commit  = (wr_state_q == WIDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
        wr_ctrl = (wr_off == OFF_CTRL);
        wr_vled = (wr_off == OFF_VLED);
        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            wr_scr[i] = (wr_off == OFF_SCRATCH + 12'(4 * i));
        end
        wr_ok    = wr_ctrl | wr_vled | (|wr_scr);
        vled_new = vled_q;
        if (wr_strb[0]) vled_new[7:0]  = wr_data[7:0];
        if (wr_strb[1]) vled_new[15:8] = wr_data[15:8];
    end

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WIDLE:   if (commit) wr_state_d = WRESP;
            WRESP:   if (bready) wr_state_d = WIDLE;
            default: wr_state_d = WIDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            wr_state_q <= WIDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
            ctrl_en_q  <= 1'b0;
            cnt_clr_q  <= 1'b0;
            vled_q     <= '0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            if (aw_hs) awaddr_q <= {awaddr[11:2], 2'b00};
            if (w_hs) begin
                wdata_q <= wdata;
                wstrb_q <= wstrb;
            end
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) aw_held_q <= 1'b1;
                if (w_hs)  w_held_q  <= 1'b1;
            end
            cnt_clr_q <= commit & wr_ctrl & wr_strb[0] & wr_data[1];
            if (commit) begin
                bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_ctrl && wr_strb[0]) ctrl_en_q <= wr_data[0];
                if (wr_vled) vled_q <= vled_new;
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (wr_scr[i]) scratch_q[i] <= apply_strb(scratch_q[i], wr_data, wr_strb);
                end
            end
        end
    end

    always_comb begin
        rd_off  = {araddr[11:2], 2'b00};
        rd_data = UNIMPL_VALUE;
        rd_ok   = 1'b0;
        case (rd_off)
            OFF_ID:     begin rd_data = ID_VALUE;              rd_ok = 1'b1; end
            OFF_CTRL:   begin rd_data = {31'b0, ctrl_en_q};    rd_ok = 1'b1; end
            OFF_CNT_LO: begin rd_data = cnt_lo;                rd_ok = 1'b1; end
            OFF_CNT_HI: begin rd_data = cnt_hi_snap;           rd_ok = 1'b1; end
            OFF_VLED:   begin rd_data = {16'b0, vled_q};       rd_ok = 1'b1; end
            default: begin
                for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                    if (rd_off == OFF_SCRATCH + 12'(4 * i)) begin
                        rd_data = scratch_q[i];
                        rd_ok   = 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RIDLE:   if (ar_hs) rd_state_d = RRESP;
            RRESP:   if (rready) rd_state_d = RIDLE;
            default: rd_state_d = RIDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            rd_state_q <= RIDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            if (ar_hs) begin
                rdata_q <= rd_data;
                rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    cl_ocl_csr_cycle_cnt u_cycle_cnt (
        .clk_main_a0 (clk_main_a0),
        .rst_main_n  (rst_main_n),
        .en          (ctrl_en_q),
        .clr         (cnt_clr_q),
        .snap        (ar_hs && (rd_off == OFF_CNT_LO)),
        .cnt_lo      (cnt_lo),
        .cnt_hi_snap (cnt_hi_snap)
    );

endmodule
